// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - parameterised up/down counter with terminal-count flags and wrap pulse
// Define UP_DOWN_COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module up_down_counter #(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             end_hit;

  always_comb begin
    at_max = (count_q == MAX_VAL);
    at_min = (count_q == MIN_VAL);
  end

  // end_hit: this edge would step past the end of the range in the requested direction
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    end_hit = up ? at_max : at_min;
`ifdef UP_DOWN_COUNTER_SAT_EN
    wrap_d = end_hit;
    if (!end_hit) begin
      count_d = up ? (count_q + ONE) : (count_q - ONE);
    end
`else
    wrap_d  = end_hit;
    count_d = up ? (count_q + ONE) : (count_q - ONE);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - directed self-checking bench for up_down_counter (both builds via UP_DOWN_COUNTER_SAT_EN)
module tb_up_down_counter;

  logic       clk;
  logic       rst_a, rst_b;
  logic       up_a, up_b;
  logic [2:0] count_a;
  logic [3:0] count_b;
  logic       at_max_a, at_min_a, wrap_a;
  logic       at_max_b, at_min_b, wrap_b;

  int n_checks;
  int n_errors;

  up_down_counter #(.WIDTH(3), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(rst_a), .up(up_a),
    .count(count_a), .at_max(at_max_a), .at_min(at_min_a), .wrap(wrap_a)
  );

  up_down_counter #(.WIDTH(4), .RESET_VAL(15)) dut_b (
    .clk(clk), .reset(rst_b), .up(up_b),
    .count(count_b), .at_max(at_max_b), .at_min(at_min_b), .wrap(wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive direction, take one rising edge, sample 1 time unit later
  task automatic step_a(input logic u);
    up_a = u;
    @(posedge clk);
    #1;
  endtask

  // reset dut_a away from an edge, then release with count = 0
  task automatic reset_a();
    @(posedge clk);
    #2 rst_a = 1'b0;
    #2 rst_a = 1'b1;
    #1;
  endtask

  logic [2:0] seq_up_cnt  [4];
  logic       seq_up_wrap [4];
  logic       seq_up_min  [4];
  logic       tog_dir     [4];
  logic [2:0] tog_cnt     [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    up_a  = 1'b0;
    up_b  = 1'b1;

`ifdef UP_DOWN_COUNTER_SAT_EN
    seq_up_cnt  = '{3'd6, 3'd7, 3'd7, 3'd7};
    seq_up_wrap = '{1'b0, 1'b0, 1'b1, 1'b1};
    seq_up_min  = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    seq_up_cnt  = '{3'd6, 3'd7, 3'd0, 3'd1};
    seq_up_wrap = '{1'b0, 1'b0, 1'b1, 1'b0};
    seq_up_min  = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
    tog_dir = '{1'b1, 1'b0, 1'b1, 1'b0};
    tog_cnt = '{3'd4, 3'd3, 3'd4, 3'd3};

    // reset held: edges have no effect
    #1;
    check("rst_count", count_a, 0);
    check("rst_at_min", at_min_a, 1);
    check("rst_at_max", at_max_a, 0);
    check("rst_wrap", wrap_a, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_count", count_a, 0);

    // release and count down from 0
    #3 rst_a = 1'b1;
    step_a(1'b0);
`ifdef UP_DOWN_COUNTER_SAT_EN
    check("down1_count", count_a, 0);
    check("down1_wrap", wrap_a, 1);
    check("down1_at_min", at_min_a, 1);
    step_a(1'b0);
    check("down2_count", count_a, 0);
    check("down2_wrap", wrap_a, 1);
`else
    check("down1_count", count_a, 7);
    check("down1_wrap", wrap_a, 1);
    check("down1_at_max", at_max_a, 1);
    step_a(1'b0);
    check("down2_count", count_a, 6);
    check("down2_wrap", wrap_a, 0);
    step_a(1'b1);
    step_a(1'b0);
    step_a(1'b1);
    check("wrap_pending_count", count_a, 7);
    step_a(1'b1);
    check("wrap_pending_wrap", wrap_a, 1);
`endif
    // async reset clears a live wrap pulse before the next edge
    #3 rst_a = 1'b0;
    #1;
    check("async_wrap_clear", wrap_a, 0);
    check("async_wrap_count", count_a, 0);
    #2 rst_a = 1'b1;
    #1;

    // count up through the top of the range
    reset_a();
    repeat (5) step_a(1'b1);
    check("pre_up_count", count_a, 5);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1);
      check($sformatf("up%0d_count", i), count_a, seq_up_cnt[i]);
      check($sformatf("up%0d_wrap", i), wrap_a, seq_up_wrap[i]);
      check($sformatf("up%0d_at_min", i), at_min_a, seq_up_min[i]);
    end

    // direction toggling in mid range
    reset_a();
    repeat (3) step_a(1'b1);
    check("pre_tog_count", count_a, 3);
    for (int i = 0; i < 4; i++) begin
      step_a(tog_dir[i]);
      check($sformatf("tog%0d_count", i), count_a, tog_cnt[i]);
      check($sformatf("tog%0d_wrap", i), wrap_a, 0);
    end

    // asynchronous reset mid-count
    reset_a();
    repeat (6) step_a(1'b1);
    check("pre_async_count", count_a, 6);
    #3 rst_a = 1'b0;
    #1;
    check("async_count", count_a, 0);
    check("async_wrap", wrap_a, 0);
    repeat (2) @(posedge clk);
    #1;
    check("async_hold_count", count_a, 0);
    #3 rst_a = 1'b1;
    step_a(1'b1);
    check("release_first_count", count_a, 1);

    // RESET_VAL override on the 4-bit instance
    check("b_rst_count", count_b, 15);
    check("b_rst_at_max", at_max_b, 1);
    check("b_rst_wrap", wrap_b, 0);
    #2 rst_b = 1'b1;
    @(posedge clk);
    #1;
`ifdef UP_DOWN_COUNTER_SAT_EN
    check("b_first_count", count_b, 15);
`else
    check("b_first_count", count_b, 0);
    check("b_first_at_min", at_min_b, 1);
`endif
    check("b_first_wrap", wrap_b, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
